// File: rtl/hazard_grid_encoder.sv
// Streaming hazard-box to occupancy-grid encoder: boxes accumulate per frame, mask is held on out_valid until taken.
// Optional HAZARD_OCC_COUNT_EN adds out_occ, the registered popcount of out_mask.
module hazard_grid_encoder #(
  parameter int IMG_W       = 26,
  parameter int IMG_H       = 8,
  parameter int GRID_COLS   = 8,
  parameter int GRID_ROWS   = 4,
  parameter int COORD_W     = 5,
  parameter int MAX_HAZARDS = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_box_vld,
  input  logic                                   in_last,
  input  logic [COORD_W-1:0]                     in_top,
  input  logic [COORD_W-1:0]                     in_bottom,
  input  logic [COORD_W-1:0]                     in_left,
  input  logic [COORD_W-1:0]                     in_right,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [GRID_ROWS*GRID_COLS-1:0]         out_mask,
  output logic [$clog2(MAX_HAZARDS+1)-1:0]       out_num,
  output logic                                   out_bad,
  output logic                                   out_ovf
`ifdef HAZARD_OCC_COUNT_EN
  ,
  output logic [$clog2(GRID_ROWS*GRID_COLS+1)-1:0] out_occ
`endif
);

  localparam int CELL_W = IMG_W / GRID_COLS;
  localparam int CELL_H = IMG_H / GRID_ROWS;
  localparam int CELLS  = GRID_ROWS * GRID_COLS;
  localparam int NUM_W  = $clog2(MAX_HAZARDS + 1);
  localparam int OCC_W  = $clog2(CELLS + 1);

  typedef enum logic {ACCUM, OUTPUT} state_t;

  state_t             state_q, state_d;
  logic               live_q, live_d;
  logic [CELLS-1:0]   mask_q, mask_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic               bad_q, bad_d;
  logic               ovf_q, ovf_d;
  logic [CELLS-1:0]   box_cells;
  logic               accept;
  logic               malformed;
`ifdef HAZARD_OCC_COUNT_EN
  logic [OCC_W-1:0]   occ_q, occ_d;
`endif

  // Saturate a coordinate into the image, then map to a cell; remainder pixels fall into the last cell.
  function automatic int col_of(input logic [COORD_W-1:0] x);
    int v;
    v = int'(x);
    if (v > IMG_W - 1) v = IMG_W - 1;
    v = v / CELL_W;
    if (v > GRID_COLS - 1) v = GRID_COLS - 1;
    return v;
  endfunction

  function automatic int row_of(input logic [COORD_W-1:0] y);
    int v;
    v = int'(y);
    if (v > IMG_H - 1) v = IMG_H - 1;
    v = v / CELL_H;
    if (v > GRID_ROWS - 1) v = GRID_ROWS - 1;
    return v;
  endfunction

  assign in_ready  = live_q && (state_q == ACCUM);
  assign out_valid = (state_q == OUTPUT);
  assign accept    = in_valid && in_ready;
  assign malformed = (in_top > in_bottom) || (in_left > in_right);

  // Stage 0: rectangle of cells covered by the incoming box
  always_comb begin
    int r_lo, r_hi, c_lo, c_hi;
    box_cells = '0;
    r_lo = row_of(in_top);
    r_hi = row_of(in_bottom);
    c_lo = col_of(in_left);
    c_hi = col_of(in_right);
    for (int r = 0; r < GRID_ROWS; r++) begin
      for (int c = 0; c < GRID_COLS; c++) begin
        if (r >= r_lo && r <= r_hi && c >= c_lo && c <= c_hi)
          box_cells[r*GRID_COLS + c] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    live_d  = 1'b1;
    mask_d  = mask_q;
    num_d   = num_q;
    bad_d   = bad_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (in_box_vld) begin
            if (num_q == NUM_W'(MAX_HAZARDS)) begin
              ovf_d = 1'b1;
            end else if (malformed) begin
              bad_d = 1'b1;
            end else begin
              mask_d = mask_q | box_cells;
              num_d  = num_q + NUM_W'(1);
            end
          end
          if (in_last) state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d = ACCUM;
          mask_d  = '0;
          num_d   = '0;
          bad_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

`ifdef HAZARD_OCC_COUNT_EN
  assign occ_d   = OCC_W'($countones(mask_d));
  assign out_occ = occ_q;
`endif

  // Stage 1: frame accumulator and held output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      live_q  <= 1'b0;
      mask_q  <= '0;
      num_q   <= '0;
      bad_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef HAZARD_OCC_COUNT_EN
      occ_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      mask_q  <= mask_d;
      num_q   <= num_d;
      bad_q   <= bad_d;
      ovf_q   <= ovf_d;
`ifdef HAZARD_OCC_COUNT_EN
      occ_q   <= occ_d;
`endif
    end
  end

  assign out_mask = mask_q;
  assign out_num  = num_q;
  assign out_bad  = bad_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_hazard_grid_encoder.sv
// Bench for hazard_grid_encoder: directed frames plus random frames against a pixel-level reference model.
module tb_hazard_grid_encoder;

  localparam int IMG_W = 26, IMG_H = 8, GC = 8, GR = 4, CW = 5, MAXH = 16;
  localparam int NUM_W = $clog2(MAXH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_box_vld = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] in_top = '0, in_bottom = '0, in_left = '0, in_right = '0;
  logic in_ready, out_valid, out_bad, out_ovf;
  logic [GR*GC-1:0] out_mask;
  logic [NUM_W-1:0] out_num;
`ifdef HAZARD_OCC_COUNT_EN
  logic [$clog2(GR*GC+1)-1:0] out_occ;
`endif

  hazard_grid_encoder #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .GRID_COLS(GC), .GRID_ROWS(GR),
    .COORD_W(CW), .MAX_HAZARDS(MAXH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_box_vld(in_box_vld), .in_last(in_last),
    .in_top(in_top), .in_bottom(in_bottom), .in_left(in_left), .in_right(in_right),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask), .out_num(out_num),
    .out_bad(out_bad), .out_ovf(out_ovf)
`ifdef HAZARD_OCC_COUNT_EN
    , .out_occ(out_occ)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] t, b, l, r;
    logic          v;
  } beat_t;

  beat_t frame_q[$];
  int n_vec = 0;
  int n_err = 0;

  logic [GR*GC-1:0] exp_mask;
  int               exp_num;
  logic             exp_bad, exp_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] ref_v);
    n_vec++;
    if (obs !== ref_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, ref_v, $time);
    end
  endtask

  // Reference: walk every pixel of the clamped box and mark its cell.
  function automatic logic [GR*GC-1:0] box_mask(input beat_t bt);
    logic [GR*GC-1:0] m;
    int y0, y1, x0, x1, cr, cc;
    m  = '0;
    y0 = (int'(bt.t) > IMG_H - 1) ? IMG_H - 1 : int'(bt.t);
    y1 = (int'(bt.b) > IMG_H - 1) ? IMG_H - 1 : int'(bt.b);
    x0 = (int'(bt.l) > IMG_W - 1) ? IMG_W - 1 : int'(bt.l);
    x1 = (int'(bt.r) > IMG_W - 1) ? IMG_W - 1 : int'(bt.r);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        cr = y / (IMG_H / GR); if (cr > GR - 1) cr = GR - 1;
        cc = x / (IMG_W / GC); if (cc > GC - 1) cc = GC - 1;
        m[cr*GC + cc] = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic model_clear();
    exp_mask = '0; exp_num = 0; exp_bad = 1'b0; exp_ovf = 1'b0;
  endtask

  task automatic model_beat(input beat_t bt);
    if (bt.v) begin
      if (exp_num >= MAXH) exp_ovf = 1'b1;
      else if (bt.t > bt.b || bt.l > bt.r) exp_bad = 1'b1;
      else begin
        exp_mask = exp_mask | box_mask(bt);
        exp_num++;
      end
    end
  endtask

  // Drive one beat and wait (bounded) for its acceptance; returns at accept edge + 1.
  task automatic send_beat(input beat_t bt, input logic last, input int gap, output logic ok);
    ok = 1'b0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_top = CW'($urandom); in_bottom = CW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_box_vld = bt.v; in_last = last;
    in_top = bt.t; in_bottom = bt.b; in_left = bt.l; in_right = bt.r;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_beat(bt);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".in_ready"},  64'(in_ready), 64'd0);
    chk({tag, ".out_mask"},  64'(out_mask), 64'(exp_mask));
    chk({tag, ".out_num"},   64'(out_num), 64'(exp_num));
    chk({tag, ".out_bad"},   64'(out_bad), 64'(exp_bad));
    chk({tag, ".out_ovf"},   64'(out_ovf), 64'(exp_ovf));
`ifdef HAZARD_OCC_COUNT_EN
    chk({tag, ".out_occ"},   64'(out_occ), 64'($countones(exp_mask)));
`endif
  endtask

  task automatic play_frame(input string tag, input int hold, input int max_gap);
    logic ok;
    model_clear();
    for (int i = 0; i < frame_q.size(); i++) begin
      send_beat(frame_q[i], (i == frame_q.size() - 1), $urandom_range(max_gap, 0), ok);
      if (!ok) return;
    end
    check_outputs(tag);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_outputs({tag, ".hold"});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".clr_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".clr_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".clr_mask"},  64'(out_mask), 64'd0);
    chk({tag, ".clr_num"},   64'(out_num), 64'd0);
    chk({tag, ".clr_flags"}, 64'({out_bad, out_ovf}), 64'd0);
  endtask

  function automatic beat_t mk(input int t, input int b, input int l, input int r, input logic v);
    beat_t bt;
    bt.t = CW'(t); bt.b = CW'(b); bt.l = CW'(l); bt.r = CW'(r); bt.v = v;
    return bt;
  endfunction

  initial begin
    logic ok;
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_mask", 64'(out_mask), 64'd0);
    chk("rst.out_num", 64'(out_num), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.ready_after", 64'(in_ready), 64'd1);
    chk("rst.flags", 64'({out_bad, out_ovf}), 64'd0);

    frame_q = {mk(0, 1, 0, 2, 1)};
    play_frame("t1", 0, 0);
    chk("t1.mask_const", 64'(exp_mask), 64'h1);

    frame_q = {mk(2, 5, 3, 8, 1)};
    play_frame("t2", 1, 0);
    chk("t2.mask_const", 64'(exp_mask), 64'h00060600);

    frame_q = {mk(6, 7, 24, 25, 1), mk(0, 0, 0, 0, 1)};
    play_frame("t3", 0, 1);
    chk("t3.mask_const", 64'(exp_mask), 64'h80000001);

    frame_q = {mk(0, 0, 0, 0, 0)};
    play_frame("t4", 0, 0);

    frame_q = {mk(5, 2, 0, 2, 1), mk(0, 1, 0, 2, 1)};
    play_frame("t5", 0, 0);
    chk("t5.bad_const", 64'(exp_bad), 64'd1);

    frame_q = {};
    for (int i = 0; i < 17; i++) frame_q.push_back(mk(0, 1, 0, 2, 1));
    play_frame("t6", 5, 0);
    chk("t6.ovf_const", 64'({exp_ovf, 5'(exp_num)}), 64'h30);

    // Reset in the middle of a frame must discard it.
    send_beat(mk(0, 7, 0, 25, 1), 1'b0, 0, ok);
    send_beat(mk(2, 3, 4, 5, 1), 1'b0, 0, ok);
    rst_n = 1'b0; #1;
    chk("midrst.in_ready", 64'(in_ready), 64'd0);
    chk("midrst.mask", 64'(out_mask), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    frame_q = {mk(0, 0, 0, 0, 0)};
    play_frame("midrst.empty", 0, 0);

    for (int f = 0; f < 40; f++) begin
      int nb;
      nb = $urandom_range(20, 1);
      frame_q = {};
      for (int i = 0; i < nb; i++)
        frame_q.push_back(mk($urandom_range(31, 0), $urandom_range(31, 0),
                             $urandom_range(31, 0), $urandom_range(31, 0),
                             ($urandom_range(9, 0) != 0)));
      play_frame($sformatf("rnd%0d", f), $urandom_range(4, 0), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
